// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 6-bit serial instruction link (issue and fetch sides).
// Opcode values, link words, the packed decoded-instruction type and the immediate-form test.
package isa_pkg;

    localparam int OPC_W  = 3;
    localparam int REG_W  = 3;
    localparam int IMM_W  = 8;
    localparam int WORD_W = 6;

    localparam logic [OPC_W-1:0] OP_NOP = 3'b000;
    localparam logic [OPC_W-1:0] OP_R1  = 3'b001;
    localparam logic [OPC_W-1:0] OP_I2  = 3'b010;
    localparam logic [OPC_W-1:0] OP_R3  = 3'b011;
    localparam logic [OPC_W-1:0] OP_I4  = 3'b100;
    localparam logic [OPC_W-1:0] OP_R5  = 3'b101;
    localparam logic [OPC_W-1:0] OP_I6  = 3'b110;
    localparam logic [OPC_W-1:0] OP_I7  = 3'b111;

    localparam logic [WORD_W-1:0] SYNC_WORD = 6'b111111;
    localparam logic [WORD_W-1:0] NOP_WORD  = 6'b000000;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] src_a;
        logic [REG_W-1:0] src_b;
        logic [REG_W-1:0] dest;
        logic [IMM_W-1:0] imm;
    } instr_t;

    // Immediate forms carry dest plus the 8-bit immediate over two trailing words.
    function automatic logic is_imm(input logic [OPC_W-1:0] opcode);
        return (opcode == OP_I2) || (opcode == OP_I4) || (opcode == OP_I6) || (opcode == OP_I7);
    endfunction

endpackage

// File: rtl/instr_issue_if.sv
// Decoded-instruction handshake into instr_issue; source holds fields stable while valid && !ready.
interface instr_issue_if;
    import isa_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OPC_W-1:0] in_opcode;
    logic [REG_W-1:0] in_src_a;
    logic [REG_W-1:0] in_src_b;
    logic [REG_W-1:0] in_dest;
    logic [IMM_W-1:0] in_imm;

    modport master (
        output in_valid, in_opcode, in_src_a, in_src_b, in_dest, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_src_a, in_src_b, in_dest, in_imm,
        output in_ready
    );

endinterface

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO; head visible combinationally, a push lands one edge later.
// Push ignored when full, pop ignored when empty; simultaneous push/pop allowed.
module instr_fifo
    import isa_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  instr_t push_dat,
    input  logic   pop,
    output instr_t pop_dat,
    output logic   full,
    output logic   empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    instr_t        mem_q [DEPTH];
    instr_t        mem_d [DEPTH];
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem_q[rd_ptr_q];

    // Pointers are log2(DEPTH) wide, so the increment wraps modulo DEPTH by itself.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instr_issue.sv
// Serial link transmitter: buffers decoded instructions and emits 1-3 six-bit words each,
// SYNC once after reset then NOP when idle; first word one edge after push, in_ready = FIFO not full.
module instr_issue
    import isa_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    instr_issue_if.slave      in_if,
    output logic [WORD_W-1:0] tx_word,
    output logic              tx_last,
    output logic              busy
);

    typedef enum logic [1:0] {S_FIRST, S_W2, S_W3} state_t;

    // Only the fields still needed after the first word are held.
    typedef struct packed {
        logic             imm_op;
        logic [REG_W-1:0] dest;
        logic [REG_W-1:0] src_b;
        logic [IMM_W-1:0] imm;
    } hold_t;

    state_t            state_q, state_d;
    hold_t             hold_q, hold_d;
    logic [WORD_W-1:0] tx_word_q, tx_word_d;
    logic              tx_last_q, tx_last_d;

    instr_t in_dat, head;
    logic   fifo_pop, fifo_full, fifo_empty;

    assign in_dat = '{opcode: in_if.in_opcode, src_a: in_if.in_src_a, src_b: in_if.in_src_b,
                      dest: in_if.in_dest, imm: in_if.in_imm};

    instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_if.in_valid),
        .push_dat (in_dat),
        .pop      (fifo_pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign in_if.in_ready = !fifo_full;
    assign busy           = !fifo_empty || (state_q != S_FIRST);
    assign tx_word        = tx_word_q;
    assign tx_last        = tx_last_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        tx_word_d = NOP_WORD;
        tx_last_d = 1'b0;
        fifo_pop  = 1'b0;
        case (state_q)
            S_FIRST: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    hold_d    = '{imm_op: is_imm(head.opcode), dest: head.dest,
                                  src_b: head.src_b, imm: head.imm};
                    tx_word_d = {head.opcode, head.src_a};
                    if (head.opcode == OP_NOP) begin
                        tx_last_d = 1'b1;
                    end else begin
                        state_d = S_W2;
                    end
                end
            end
            S_W2: begin
                if (hold_q.imm_op) begin
                    tx_word_d = {hold_q.dest, hold_q.imm[7:5]};
                    state_d   = S_W3;
                end else begin
                    tx_word_d = {hold_q.dest, hold_q.src_b};
                    tx_last_d = 1'b1;
                    state_d   = S_FIRST;
                end
            end
            S_W3: begin
                tx_word_d = {1'b0, hold_q.imm[4:0]};
                tx_last_d = 1'b1;
                state_d   = S_FIRST;
            end
            default: state_d = S_FIRST;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FIRST;
            tx_word_q <= SYNC_WORD;
            tx_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_word_q <= tx_word_d;
            tx_last_q <= tx_last_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

endmodule

// File: doc/instr_issue.md
Name: instr_issue

Overview:
- Transmit side of the 6-bit serial instruction link; `instr_fetch` is the receive side.
- Accepts decoded instructions (opcode, src_a, src_b, dest, imm) over a valid/ready handshake.
- Buffers them in a small FIFO and serializes each one into 1–3 six-bit words on `tx_word`.
- The sync word is emitted once after reset. When no instruction is pending, NOP words are emitted.

Parameters:
- FIFO_DEPTH, 2, instruction buffer entries; power of 2, ≥2.

Ports:
- clk       input   1  clock
- rst       input   1  reset; asynchronous, active-high
- in_valid  input   1  instruction offered
- in_ready  output  1  FIFO can accept (= not full)
- in_opcode input   3  opcode
- in_src_a  input   3  source A register
- in_src_b  input   3  source B register
- in_dest   input   3  destination register
- in_imm    input   8  immediate
- tx_word   output  6  serial link word, registered, one word per cycle
- tx_last   output  1  registered; high while `tx_word` holds the final word of a FIFO-sourced instruction
- busy      output  1  FIFO non-empty or FSM not in S_FIRST

Behaviour:
- Reset (async):
  - `tx_word` = 6'b111111 (SYNC); `tx_last` = 0.
  - FSM = S_FIRST; FIFO emptied; `in_ready` = 1.
  - Holding register contents are don't-care.
- Sync:
  - SYNC appears on `tx_word` for exactly one cycle: from reset until the first posedge after release.
  - The next edge always loads a first word (instruction or NOP).
  - SYNC is never re-emitted without reset; a second 6'b111111 would decode as opcode 111.
- Handshake:
  - Push when `in_valid` && `in_ready` at posedge.
  - `in_ready` = !full, combinational from FIFO count.
  - Pop and push in the same cycle are allowed; when full, only pop proceeds.
- Word encoding, with the instruction latched in a holding register on pop:
  - W1 = {opcode, src_a}
  - Opcode 000: 1 word only; src_b, dest, imm are ignored.
  - Imm opcodes (010, 100, 110, 111): W2 = {dest, imm[7:5]}, W3 = {1'b0, imm[4:0]}.
  - Others (001, 011, 101): W2 = {dest, src_b}; 2 words.
- FSM. The state names the word loaded at the next edge.
  - S_FIRST, FIFO non-empty: pop; `tx_word` <= W1; next state S_W2, or S_FIRST if opcode == 000. `tx_last` <= (opcode == 000).
  - S_FIRST, FIFO empty: `tx_word` <= NOP (6'b000000); `tx_last` <= 0; stay.
  - S_W2: `tx_word` <= W2; next S_W3 if imm opcode, else S_FIRST. `tx_last` <= !imm.
  - S_W3: `tx_word` <= W3; `tx_last` <= 1; next S_FIRST.
- NOP semantics: {000, 000} is the architectural NOP. The receiver reports it as `op_valid`; downstream ignores it.
- Latency: push at edge N into an empty FIFO with FSM in S_FIRST → W1 on `tx_word` after edge N+1.
- Back-to-back: the next instruction's W1 follows the previous last word with no gap. Sustained rate is one instruction per 1/2/3 cycles.
- Boundaries:
  - Full FIFO: `in_ready` = 0 and the offered instruction is held by the source.
  - FIFO pointers wrap modulo FIFO_DEPTH; count is stored at log2(FIFO_DEPTH)+1 bits.
  - Reset mid-instruction: the partial instruction and all buffered instructions are dropped.
  - The receiver shares `rst`, so both ends resynchronize on the SYNC word.

Decomposition:
- Package `isa_pkg`:
  - Opcode localparams.
  - SYNC_WORD and NOP_WORD.
  - Field widths.
  - `is_imm(opcode)` function, shared with `instr_fetch`.
  - Packed instruction struct/typedef (20 bits).
- Sub-module `instr_fifo`: synchronous FIFO of the 20-bit instruction with push/pop/full/empty; parameter DEPTH.
- `instr_issue` contains the FSM, holding register and word mux.

Test Plan:
- Reset release, no input → `tx_word` 0x3F for one cycle, then 0x00 every cycle; `tx_last` = 0; `busy` = 0.
- Push {op=000, a=5} → one word 0x05 with `tx_last` = 1; then NOP.
- Push {op=011, a=2, b=6, d=1} → 0x1A, then 0x0E (`tx_last` = 1 on the second word).
- Push {op=110, a=3, d=4, imm=0xB7} → 0x33, 0x25, 0x17; `tx_last` only on 0x17.
- Four instructions offered back-to-back with DEPTH=2:
  - `in_ready` drops while the FIFO is full.
  - Output words are gapless and in order.
  - Loopback into `instr_fetch` yields matching fields on each `op_valid`, with NOPs filtered.
- Assert `rst` during W2 of an imm opcode with the FIFO full → `tx_word` = 0x3F immediately; FIFO empty; `in_ready` = 1; after release, only NOPs.
